// File: rtl/fht_io_sequencer.sv
// rtl/fht_io_sequencer.sv - frame load, start and natural-order unload sequencer for the FHT core
module fht_io_sequencer #(
  parameter int D_BIT  = 17,
  parameter int A_BIT  = 8,
  parameter int BITREV = 1,
  parameter int RD_LAT = 2
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic                    iENABLE,
  input  logic [D_BIT-2:0]        iSAMPLE,
  input  logic                    iSAMPLE_VALID,
  output logic                    oSAMPLE_READY,
  output logic [D_BIT-2:0]        oDATA,
  output logic [A_BIT-1:0]        oADDR_WR,
  output logic                    oWE_0,
  output logic                    oWE_1,
  output logic                    oWE_2,
  output logic                    oWE_3,
  output logic                    oSTART,
  input  logic                    iFHT_RDY,
  output logic [A_BIT-1:0]        oADDR_RD,
  input  logic signed [D_BIT-1:0] iFHT_DATA_0,
  input  logic signed [D_BIT-1:0] iFHT_DATA_1,
  input  logic signed [D_BIT-1:0] iFHT_DATA_2,
  input  logic signed [D_BIT-1:0] iFHT_DATA_3,
  output logic signed [D_BIT-1:0] oRESULT,
  output logic                    oRESULT_VALID,
  input  logic                    iRESULT_READY,
  output logic                    oLAST,
  output logic                    oFRAME_DONE,
  output logic                    oBUSY
);

  localparam int N_BIT = A_BIT + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]              state;
  logic [N_BIT-1:0]        n_cnt;
  logic [N_BIT-1:0]        n_rev;
  logic [N_BIT-1:0]        n_map;
  logic [3:0]              we_q;
  logic [D_BIT-2:0]        data_q;
  logic [A_BIT-1:0]        addr_wr_q;
  logic                    start_q;
  logic                    done_q;
  logic                    rdy_q;
  logic                    rdy_rise;
  logic                    accept;
  logic [N_BIT-1:0]        rd_cnt;
  logic                    rd_all;
  logic                    issue;
  logic [RD_LAT-1:0]       pipe_v;
  logic [RD_LAT-1:0]       pipe_last;
  logic [1:0]              pipe_bank [RD_LAT];
  logic [3:0]              in_flight;
  logic [3:0]              credit_used;
  logic signed [D_BIT-1:0] fifo_data [4];
  logic [3:0]              fifo_last;
  logic [1:0]              wr_ptr;
  logic [1:0]              rd_ptr;
  logic [2:0]              fifo_cnt;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic signed [D_BIT-1:0] push_data;

  assign accept      = iSAMPLE_VALID && (state == S_LOAD);
  // a level already high when the start strobe goes out must fall and rise again
  assign rdy_rise    = iFHT_RDY && !rdy_q && !start_q;
  assign credit_used = in_flight + {1'b0, fifo_cnt};
  assign issue       = (state == S_UNLOAD) && !rd_all && (credit_used < 4'd4);
  assign fifo_push   = pipe_v[RD_LAT-1];
  assign fifo_pop    = (fifo_cnt != 3'd0) && iRESULT_READY;
  assign n_map       = (BITREV != 0) ? n_rev : n_cnt;

  // reverse the load index across the full bank+address width
  always_comb begin
    n_rev = '0;
    for (int i = 0; i < N_BIT; i++) n_rev[i] = n_cnt[N_BIT-1-i];
  end

  // reads issued but not yet captured count against FIFO space
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + {3'b000, pipe_v[i]};
  end

  // pick the bank whose data returns this cycle
  always_comb begin
    case (pipe_bank[RD_LAT-1])
      2'd0:    push_data = iFHT_DATA_0;
      2'd1:    push_data = iFHT_DATA_1;
      2'd2:    push_data = iFHT_DATA_2;
      default: push_data = iFHT_DATA_3;
    endcase
  end

  // frame state machine plus start/done strobes and ready edge register
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q   <= iFHT_RDY;
      start_q <= (state == S_START);
      done_q  <= (state == S_UNLOAD) && fifo_pop && fifo_last[rd_ptr];
      case (state)
        S_IDLE:   if (iENABLE) state <= S_LOAD;
        S_LOAD:   if (accept && (&n_cnt)) state <= S_START;
        S_START:  state <= S_WAIT;
        S_WAIT:   if (rdy_rise) state <= S_UNLOAD;
        S_UNLOAD: if (fifo_pop && fifo_last[rd_ptr]) state <= S_DONE;
        S_DONE:   state <= iENABLE ? S_LOAD : S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // sample counter and registered write port into the core banks
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      n_cnt     <= '0;
      we_q      <= 4'b0000;
      data_q    <= '0;
      addr_wr_q <= '0;
    end else begin
      we_q <= accept ? (4'b0001 << n_map[1:0]) : 4'b0000;
      if (accept) begin
        n_cnt     <= n_cnt + 1'b1;
        data_q    <= iSAMPLE;
        addr_wr_q <= n_map[N_BIT-1:2];
      end
    end
  end

  // read issue counter and bank/last tags travelling alongside the RAM latency
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rd_cnt    <= '0;
      rd_all    <= 1'b0;
      pipe_v    <= '0;
      pipe_last <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_bank[i] <= 2'd0;
    end else begin
      if (state != S_UNLOAD) begin
        rd_cnt <= '0;
        rd_all <= 1'b0;
      end else if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (&rd_cnt) rd_all <= 1'b1;
      end
      pipe_v[0]    <= issue;
      pipe_last[0] <= &rd_cnt;
      pipe_bank[0] <= rd_cnt[1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
        pipe_bank[i] <= pipe_bank[i-1];
      end
    end
  end

  // four-entry result FIFO feeding the output stream
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      fifo_cnt  <= 3'd0;
      fifo_last <= 4'b0000;
      for (int i = 0; i < 4; i++) fifo_data[i] <= '0;
    end else begin
      if (fifo_push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_last[wr_ptr] <= pipe_last[RD_LAT-1];
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign oSAMPLE_READY = (state == S_LOAD);
  assign oDATA         = data_q;
  assign oADDR_WR      = addr_wr_q;
  assign oWE_0         = we_q[0];
  assign oWE_1         = we_q[1];
  assign oWE_2         = we_q[2];
  assign oWE_3         = we_q[3];
  assign oSTART        = start_q;
  assign oADDR_RD      = (state == S_UNLOAD) ? rd_cnt[N_BIT-1:2] : '0;
  assign oRESULT_VALID = (fifo_cnt != 3'd0);
  assign oRESULT       = oRESULT_VALID ? fifo_data[rd_ptr] : '0;
  assign oLAST         = oRESULT_VALID && fifo_last[rd_ptr];
  assign oFRAME_DONE   = done_q;
  assign oBUSY         = (state != S_IDLE);

endmodule

// File: tb/tb_fht_io_sequencer.sv
// tb/tb_fht_io_sequencer.sv - self-checking bench for fht_io_sequencer
module tb_fht_io_sequencer;

  localparam int N = 1024;

  logic        iCLK = 1'b0;
  logic        iRESET;
  logic        iENABLE;
  logic [15:0] iSAMPLE;
  logic        iSAMPLE_VALID;
  logic        iFHT_RDY;
  logic        iRESULT_READY;

  logic        oSAMPLE_READY, oWE_0, oWE_1, oWE_2, oWE_3, oSTART;
  logic [15:0] oDATA;
  logic [7:0]  oADDR_WR, oADDR_RD;
  logic [16:0] oRESULT;
  logic        oRESULT_VALID, oLAST, oFRAME_DONE, oBUSY;
  logic [16:0] fht_d0, fht_d1, fht_d2, fht_d3;

  logic        r0_ready, r0_we0, r0_we1, r0_we2, r0_we3, r0_start;
  logic [15:0] r0_data;
  logic [7:0]  r0_addr_wr, r0_addr_rd;
  logic [16:0] r0_result;
  logic        r0_valid, r0_last, r0_done, r0_busy;
  logic [58:0] r0_bundle;

  always #5 iCLK = ~iCLK;

  fht_io_sequencer #(.D_BIT(17), .A_BIT(8), .BITREV(1), .RD_LAT(2)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iENABLE(iENABLE),
    .iSAMPLE(iSAMPLE), .iSAMPLE_VALID(iSAMPLE_VALID), .oSAMPLE_READY(oSAMPLE_READY),
    .oDATA(oDATA), .oADDR_WR(oADDR_WR),
    .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
    .oSTART(oSTART), .iFHT_RDY(iFHT_RDY), .oADDR_RD(oADDR_RD),
    .iFHT_DATA_0(fht_d0), .iFHT_DATA_1(fht_d1), .iFHT_DATA_2(fht_d2), .iFHT_DATA_3(fht_d3),
    .oRESULT(oRESULT), .oRESULT_VALID(oRESULT_VALID), .iRESULT_READY(iRESULT_READY),
    .oLAST(oLAST), .oFRAME_DONE(oFRAME_DONE), .oBUSY(oBUSY)
  );

  fht_io_sequencer #(.D_BIT(17), .A_BIT(8), .BITREV(0), .RD_LAT(2)) dut_nat (
    .iCLK(iCLK), .iRESET(iRESET), .iENABLE(iENABLE),
    .iSAMPLE(iSAMPLE), .iSAMPLE_VALID(iSAMPLE_VALID), .oSAMPLE_READY(r0_ready),
    .oDATA(r0_data), .oADDR_WR(r0_addr_wr),
    .oWE_0(r0_we0), .oWE_1(r0_we1), .oWE_2(r0_we2), .oWE_3(r0_we3),
    .oSTART(r0_start), .iFHT_RDY(iFHT_RDY), .oADDR_RD(r0_addr_rd),
    .iFHT_DATA_0('0), .iFHT_DATA_1('0), .iFHT_DATA_2('0), .iFHT_DATA_3('0),
    .oRESULT(r0_result), .oRESULT_VALID(r0_valid), .iRESULT_READY(iRESULT_READY),
    .oLAST(r0_last), .oFRAME_DONE(r0_done), .oBUSY(r0_busy)
  );

  assign r0_bundle = {r0_ready, r0_data, r0_addr_wr, r0_we3, r0_we2, r0_we1, r0_we0, r0_start,
                      r0_addr_rd, r0_result, r0_valid, r0_last, r0_done, r0_busy};

  // core RAM model: bank b at address a holds 4*a+b, data two cycles after the address
  logic [7:0] ra_d1 = '0, ra_d2 = '0;
  always @(posedge iCLK) begin
    ra_d1 <= oADDR_RD;
    ra_d2 <= ra_d1;
  end
  assign fht_d0 = {7'd0, ra_d2, 2'd0};
  assign fht_d1 = {7'd0, ra_d2, 2'd1};
  assign fht_d2 = {7'd0, ra_d2, 2'd2};
  assign fht_d3 = {7'd0, ra_d2, 2'd3};

  typedef struct { int n; int bank; int addr; int data; } wr_t;
  typedef struct { int n; bit br; int bank; int addr; } map_t;

  int  errors = 0, checks = 0;
  int  cyc = 0, wn = 0, wr_frame = 0, res_frame = 0;
  int  last_acc_cyc = -100, first_valid_cyc = -1, rise_cyc = 0, max_occ = 0;
  bit  mon_en = 0, acc_pend = 0, done_pend = 0, done_seen = 0, hold_pend = 0, valid_seen = 0;
  logic [16:0] held;
  logic [3:0]  rr_pat = 4'b1001;
  wr_t wq[$];
  int  rq[$];
  int  rec_bank1[N], rec_addr1[N], rec_data1[N], rec_bank0[N], rec_addr0[N];
  map_t map_tbl[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] sample_of(input int n);
    logic [31:0] v;
    v = n * 40503 + 7;
    return v[15:0];
  endfunction

  function automatic int map_r(input int n, input bit br);
    int r = 0;
    if (!br) return n;
    for (int i = 0; i < 10; i++) r = r | (((n >> i) & 1) << (9 - i));
    return r;
  endfunction

  function automatic int bank_of(input logic [3:0] we);
    case (we)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic clear_recs();
    for (int i = 0; i < N; i++) begin
      rec_bank1[i] = -1; rec_addr1[i] = -1; rec_data1[i] = -1;
      rec_bank0[i] = -1; rec_addr0[i] = -1;
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
    iRESULT_READY = rr_pat[(cyc + 1) % 4];
    iSAMPLE = sample_of(wn);
  endtask

  task automatic new_frame();
    wr_frame = 0; res_frame = 0; first_valid_cyc = -1;
    valid_seen = 0; done_seen = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, oSAMPLE_READY, 0);
    chk({tag, "_data"}, oDATA, 0);
    chk({tag, "_addr_wr"}, oADDR_WR, 0);
    chk({tag, "_we"}, {oWE_3, oWE_2, oWE_1, oWE_0}, 0);
    chk({tag, "_start"}, oSTART, 0);
    chk({tag, "_addr_rd"}, oADDR_RD, 0);
    chk({tag, "_result"}, oRESULT, 0);
    chk({tag, "_valid"}, oRESULT_VALID, 0);
    chk({tag, "_last"}, oLAST, 0);
    chk({tag, "_frame_done"}, oFRAME_DONE, 0);
    chk({tag, "_busy"}, oBUSY, 0);
    chk({tag, "_natural_outputs"}, r0_bundle, 0);
  endtask

  task automatic wait_load();
    for (int i = 0; i < 3000; i++) begin
      step();
      if (wr_frame == N && cyc >= last_acc_cyc + 2) break;
    end
    chk("load_write_count", wr_frame, N);
  endtask

  task automatic raise_rdy();
    iFHT_RDY = 1'b0;
    repeat (5) step();
    for (int k = 0; k < N; k++) rq.push_back(k);
    iFHT_RDY = 1'b1;
    rise_cyc = cyc + 1;
  endtask

  // write scoreboard, start strobe, result scoreboard and stall stability
  always @(negedge iCLK) begin
    if (mon_en) begin
      logic [3:0] we1, we0;
      wr_t e;
      int exp_k;
      cyc++;
      chk("frame_done", oFRAME_DONE, done_pend);
      if (oFRAME_DONE) done_seen = 1;
      done_pend = 0;
      chk("start_pulse", oSTART, (cyc == last_acc_cyc + 2));
      if (cyc == last_acc_cyc + 1 || cyc == last_acc_cyc + 2)
        chk("ready_low_after_last", oSAMPLE_READY, 0);
      we1 = {oWE_3, oWE_2, oWE_1, oWE_0};
      we0 = {r0_we3, r0_we2, r0_we1, r0_we0};
      if (acc_pend) begin
        e = wq.pop_front();
        chk("we_onehot", we1, 4'b0001 << e.bank);
        chk("addr_wr", oADDR_WR, e.addr);
        chk("data_wr", oDATA, e.data);
        rec_bank1[e.n] = bank_of(we1);
        rec_addr1[e.n] = oADDR_WR;
        rec_data1[e.n] = oDATA;
        rec_bank0[e.n] = bank_of(we0);
        rec_addr0[e.n] = r0_addr_wr;
        wr_frame++;
      end else begin
        chk("we_idle", we1, 0);
      end
      acc_pend = iSAMPLE_VALID && oSAMPLE_READY;
      if (acc_pend) begin
        e.n = wn;
        e.bank = map_r(wn, 1) % 4;
        e.addr = map_r(wn, 1) / 4;
        e.data = sample_of(wn);
        wq.push_back(e);
        if (wn == N - 1) last_acc_cyc = cyc;
        wn = (wn + 1) % N;
      end
      if (hold_pend) begin
        chk("stall_valid_held", oRESULT_VALID, 1);
        chk("stall_result_held", oRESULT, held);
        hold_pend = 0;
      end
      if (oRESULT_VALID) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        valid_seen = 1;
        if (iRESULT_READY) begin
          exp_k = (rq.size() > 0) ? rq.pop_front() : -1;
          chk("result", oRESULT, exp_k);
          chk("last_flag", oLAST, (exp_k == N - 1));
          res_frame++;
          if (exp_k == N - 1) done_pend = 1;
        end else begin
          hold_pend = 1;
          held = oRESULT;
        end
      end
      if (int'(dut.fifo_cnt) > max_occ) max_occ = int'(dut.fifo_cnt);
    end
  end

  initial begin
    map_tbl[0] = '{n: 1,    br: 1, bank: 0, addr: 128};
    map_tbl[1] = '{n: 6,    br: 1, bank: 0, addr: 96};
    map_tbl[2] = '{n: 512,  br: 1, bank: 1, addr: 0};
    map_tbl[3] = '{n: 768,  br: 1, bank: 3, addr: 0};
    map_tbl[4] = '{n: 1023, br: 1, bank: 3, addr: 255};
    map_tbl[5] = '{n: 6,    br: 0, bank: 2, addr: 1};

    iRESET = 1'b0; iENABLE = 1'b0; iSAMPLE = '0; iSAMPLE_VALID = 1'b0;
    iFHT_RDY = 1'b0; iRESULT_READY = 1'b0;
    clear_recs();
    repeat (2) @(negedge iCLK);
    check_zero("reset");

    // frame 1: core ready level already high across the start strobe
    step();
    iENABLE = 1'b1; iSAMPLE_VALID = 1'b1; iFHT_RDY = 1'b1; iSAMPLE = sample_of(0);
    iRESET = 1'b1; mon_en = 1;
    new_frame();
    step();
    #2;
    chk("ready_after_release", oSAMPLE_READY, 1);
    wait_load();

    for (int i = 0; i < 6; i++) begin
      int ab, aa;
      ab = map_tbl[i].br ? rec_bank1[map_tbl[i].n] : rec_bank0[map_tbl[i].n];
      aa = map_tbl[i].br ? rec_addr1[map_tbl[i].n] : rec_addr0[map_tbl[i].n];
      chk($sformatf("map_n%0d_br%0d_bank", map_tbl[i].n, map_tbl[i].br), ab, map_tbl[i].bank);
      chk($sformatf("map_n%0d_br%0d_addr", map_tbl[i].n, map_tbl[i].br), aa, map_tbl[i].addr);
    end

    repeat (10) step();
    chk("no_unload_on_held_rdy", valid_seen, 0);
    chk("busy_in_wait", oBUSY, 1);
    raise_rdy();
    for (int i = 0; i < 6000; i++) begin
      step();
      if (done_seen) break;
    end
    chk("frame1_done_seen", done_seen, 1);
    chk("first_valid_latency", first_valid_cyc - rise_cyc, 4);
    chk("frame1_result_count", res_frame, N);
    chk("frame1_queue_empty", rq.size(), 0);
    chk("fifo_occupancy_within_4", (max_occ <= 4), 1);

    // frame 2 starts straight from DONE; reset lands mid-unload
    new_frame();
    wait_load();
    repeat (10) step();
    chk("frame2_no_unload_on_held_rdy", valid_seen, 0);
    raise_rdy();
    for (int i = 0; i < 3000; i++) begin
      step();
      if (res_frame >= 300) break;
    end
    chk("frame2_reached_k300", (res_frame >= 300), 1);
    #2;
    mon_en = 0;
    iRESET = 1'b0;
    #1;
    check_zero("midreset");

    wq.delete(); rq.delete(); clear_recs();
    wn = 0; acc_pend = 0; done_pend = 0; hold_pend = 0; last_acc_cyc = -100;
    repeat (3) step();
    iSAMPLE = sample_of(0);
    iRESET = 1'b1; mon_en = 1;
    new_frame();
    for (int i = 0; i < 50; i++) begin
      step();
      if (wr_frame >= 4) break;
    end
    chk("restart_write_count", (wr_frame >= 4), 1);
    chk("restart_n0_bank", rec_bank1[0], 0);
    chk("restart_n0_addr", rec_addr1[0], 0);
    chk("restart_n0_data", rec_data1[0], sample_of(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fht_io_sequencer.md
# fht_io_sequencer

Frame-level sequencer for the FHT core. It streams ADC samples into the core's four-bank input RAM in the core's load order, issues the start strobe, and waits for completion. It then reads the transformed points out in natural order as a back-pressured output stream. It sits between the ADC/sample source, the downstream consumer and the FHT core, and drives every core signal that is used while the core is idle.

## Interface
- D_BIT, 17: core data width; samples are D_BIT-1 bits, results D_BIT bits signed.
- A_BIT, 8: per-bank address width; frame length N = 4·2^A_BIT (default 1024).
- BITREV, 1: 1 = bit-reverse the sample index over A_BIT+2 bits before bank/address split; 0 = natural order.
- RD_LAT, 2: core RAM read latency in cycles (address to data).
- iCLK  in  1  clock, all logic rising-edge.
- iRESET  in  1  asynchronous, active-low reset, shared with the FHT core.
- iENABLE  in  1  level; high = run frames back-to-back.
- iSAMPLE  in  D_BIT-1  ADC sample, passed unmodified; the core sign-extends it.
- iSAMPLE_VALID  in  1  sample handshake valid.
- oSAMPLE_READY  out  1  high only in LOAD with samples outstanding.
- oDATA  out  D_BIT-1  write data to the core input port.
- oADDR_WR  out  A_BIT  write address to the core.
- oWE_0..oWE_3  out  1 each  one-hot bank write enables.
- oSTART  out  1  one-cycle start strobe to the core.
- iFHT_RDY  in  1  core ready; a pulse or a level, only its rising edge is used.
- oADDR_RD  out  A_BIT  read address, fanned out to all four core read-address inputs.
- iFHT_DATA_0..iFHT_DATA_3  in  D_BIT each  core bank read data.
- oRESULT  out  D_BIT  signed result, head of the output FIFO.
- oRESULT_VALID  out  1  head valid.
- iRESULT_READY  in  1  consumer ready.
- oLAST  out  1  qualifies the result with k = N-1.
- oFRAME_DONE  out  1  one-cycle pulse at frame end.
- oBUSY  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, LOAD, START, WAIT_RDY, UNLOAD, DONE. Reset forces IDLE, clears all counters and the FIFO, and drives every output to 0.
- IDLE → LOAD when iENABLE = 1.
- **LOAD:** the sample counter n runs 0..N-1.
  - A sample is accepted when iSAMPLE_VALID & oSAMPLE_READY.
  - r = BITREV ? bitrev(n) : n. The sample goes to bank r[1:0] at address r[A_BIT+1:2].
  - After the N-th accept, oSAMPLE_READY drops and the state goes to START.
- **START:** oSTART is high for exactly one cycle, then WAIT_RDY.
- **WAIT_RDY:** iFHT_RDY is registered. The state goes to UNLOAD on the first 0→1 transition seen after the oSTART cycle. A level already high at oSTART is ignored until it falls and rises again.
- **UNLOAD:** the result counter k runs 0..N-1.
  - Read address is k[A_BIT+1:2]. Bank index k[1:0] is delayed RD_LAT cycles and selects iFHT_DATA_x into a 4-entry FIFO.
  - A read is issued only when in-flight reads + FIFO occupancy < 4, so no data is dropped.
  - oLAST accompanies k = N-1.
- **DONE:** entered after the last result transfers. oFRAME_DONE is pulsed in DONE. Then DONE → LOAD if iENABLE = 1, else IDLE.
- Deasserting iENABLE never aborts a frame; it takes effect only at DONE.
- oWE_x are never asserted outside LOAD. oADDR_RD holds 0 outside UNLOAD.

## Timing
- **Write path:** an accept in cycle t produces oWE_b, oDATA and oADDR_WR, registered, in cycle t+1.
- **Start:** with the final accept in cycle t, the last write is in t+1 and oSTART in t+2. oSAMPLE_READY is 0 from t+1.
- **Unload entry:** an iFHT_RDY rise sampled in cycle u puts the FSM in UNLOAD at u+1.
- **First result:** with iRESULT_READY held high, the first oRESULT_VALID appears RD_LAT+1 cycles after UNLOAD entry. One result transfers per cycle thereafter.
- **Stall:** with iRESULT_READY = 0, oRESULT and oRESULT_VALID hold stable. Issue stops once the credit limit is reached.
- **Frame end:** oFRAME_DONE occurs the cycle after the transfer carrying oLAST.
- **Reset:** asynchronous assertion at any point, including mid-LOAD or mid-UNLOAD, zeros outputs immediately. The next frame restarts at n = 0.

## Test plan
- **Reset:** iRESET low → every output 0, oBUSY 0. Release with iENABLE=1 → oSAMPLE_READY 1 on the next cycle.
- **Mapping** (BITREV=1, A_BIT=8):
  - n=1 → bank0 addr128.
  - n=6 → bank0 addr96.
  - n=512 → bank1 addr0.
  - n=768 → bank3 addr0.
  - n=1023 → bank3 addr255.
  - With BITREV=0, n=6 → bank2 addr1.
- **Load timing:** 1024 back-to-back valid samples → exactly 1024 one-hot WE pulses, each 1 cycle after its accept. oSTART is a single pulse 2 cycles after the last accept, and oSAMPLE_READY is low from then on.
- **RDY edge:** iFHT_RDY held high across oSTART → no UNLOAD. Drop it for 5 cycles, then raise it → UNLOAD next cycle, first oRESULT_VALID 3 cycles later (RD_LAT=2).
- **Backpressure:** iRESULT_READY toggling 1,0,0,1 with the model memory holding value = 4·addr+bank → 1024 results k=0..1023 in order, no loss. oLAST only on k=1023. oFRAME_DONE 1 cycle after. FIFO occupancy never exceeds 4.
- **Reset mid-frame:** iRESET low at result k=300 → outputs 0 immediately. After release with iENABLE=1, the new frame writes n=0 to bank0 addr0.
